// File: rtl/fir_accum_mc.sv
// Multi-channel interleaved accumulator bank: per-channel partial sums framed by
// first/last flags, then round, arithmetic shift and saturate to the output width.
module fir_accum_mc #(
   parameter int unsigned DWIDTH   = 16,
   parameter int unsigned ACWIDTH  = 40,
   parameter int unsigned OWIDTH   = 16,
   parameter int unsigned SHIFT    = 15,
   parameter int unsigned ROUND    = 1,
   parameter int unsigned CHANNELS = 4,
   localparam int unsigned CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     valid_i,
   input  logic                     first_i,
   input  logic                     last_i,
   input  logic [CHW-1:0]           chan_i,
   input  logic signed [DWIDTH-1:0] data_i,
   output logic                     valid_o,
   output logic [CHW-1:0]           chan_o,
   output logic signed [OWIDTH-1:0] data_o,
   output logic                     sat_o,
   output logic                     err_o
);

   localparam int unsigned RWIDTH = ACWIDTH + 1;

   // Half-LSB rounding constant; zero when truncating or not shifting.
   localparam logic signed [RWIDTH-1:0] RND_C =
      (ROUND != 0 && SHIFT > 0) ? (RWIDTH'(1) << (SHIFT - 1)) : '0;
   localparam logic signed [RWIDTH-1:0] MAX_C =
      {{(ACWIDTH - OWIDTH + 2){1'b0}}, {(OWIDTH - 1){1'b1}}};
   localparam logic signed [RWIDTH-1:0] MIN_C = ~MAX_C;

   logic signed [ACWIDTH-1:0] acc_q [CHANNELS];
   logic signed [ACWIDTH-1:0] acc_d [CHANNELS];

   logic                      s1_vld_q, s1_vld_d;
   logic signed [ACWIDTH-1:0] s1_sum_q, s1_sum_d;
   logic [CHW-1:0]            s1_chan_q, s1_chan_d;

   logic                      valid_q, valid_d;
   logic [CHW-1:0]            chan_q, chan_d;
   logic signed [OWIDTH-1:0]  data_q, data_d;
   logic                      sat_q, sat_d;
   logic                      err_q, err_d;

   logic                      chan_ok_c;
   logic                      accept_c;
   logic signed [ACWIDTH-1:0] acc_sel_c;
   logic signed [ACWIDTH-1:0] sum_c;
   logic signed [RWIDTH-1:0]  rnd_sum_c;
   logic signed [RWIDTH-1:0]  shq_c;

   // Stage 0: select, accumulate or load, and capture finished sums.
   always_comb begin
      chan_ok_c = {1'b0, chan_i} < (CHW + 1)'(CHANNELS);
      accept_c  = valid_i && chan_ok_c && !clr_i;
      acc_sel_c = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (chan_i == CHW'(i)) acc_sel_c = acc_q[i];
      end
      sum_c = (first_i ? ACWIDTH'(0) : acc_sel_c) + ACWIDTH'(data_i);

      for (int i = 0; i < int'(CHANNELS); i++) begin
         acc_d[i] = acc_q[i];
         if (clr_i)                                acc_d[i] = '0;
         else if (accept_c && chan_i == CHW'(i))   acc_d[i] = sum_c;
      end

      s1_vld_d  = accept_c && last_i;
      s1_sum_d  = s1_sum_q;
      s1_chan_d = s1_chan_q;
      if (s1_vld_d) begin
         s1_sum_d  = sum_c;
         s1_chan_d = chan_i;
      end
      err_d = valid_i && !chan_ok_c;
   end

   // Stage 2: round in one extra bit so the offset cannot wrap, shift, clamp.
   always_comb begin
      rnd_sum_c = RWIDTH'(s1_sum_q) + RND_C;
      shq_c     = rnd_sum_c >>> SHIFT;
      valid_d   = s1_vld_q;
      chan_d    = chan_q;
      data_d    = data_q;
      sat_d     = sat_q;
      if (s1_vld_q) begin
         chan_d = s1_chan_q;
         if (shq_c > MAX_C) begin
            data_d = OWIDTH'(MAX_C);
            sat_d  = 1'b1;
         end else if (shq_c < MIN_C) begin
            data_d = OWIDTH'(MIN_C);
            sat_d  = 1'b1;
         end else begin
            data_d = OWIDTH'(shq_c);
            sat_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(CHANNELS); i++) acc_q[i] <= '0;
         s1_vld_q  <= 1'b0;
         s1_sum_q  <= '0;
         s1_chan_q <= '0;
         valid_q   <= 1'b0;
         chan_q    <= '0;
         data_q    <= '0;
         sat_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         for (int i = 0; i < int'(CHANNELS); i++) acc_q[i] <= acc_d[i];
         s1_vld_q  <= s1_vld_d;
         s1_sum_q  <= s1_sum_d;
         s1_chan_q <= s1_chan_d;
         valid_q   <= valid_d;
         chan_q    <= chan_d;
         data_q    <= data_d;
         sat_q     <= sat_d;
         err_q     <= err_d;
      end
   end

   assign valid_o = valid_q;
   assign chan_o  = chan_q;
   assign data_o  = data_q;
   assign sat_o   = sat_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_fir_accum_mc.sv
// Scoreboard bench: three builds (A: SHIFT=2 round, B: SHIFT=2 truncate, C: SHIFT=0 round)
// share one stimulus stream; each has its own expected-result queue.
module tb_fir_accum_mc;

   localparam int unsigned CHW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, clr, vld, fst, lst;
   logic [CHW-1:0]     ch;
   logic signed [15:0] din;

   logic va, vb, vc, sa, sb, sc, ea, eb, ec;
   logic [CHW-1:0] cha, chb, chc;
   logic signed [15:0] da, db, dc;

   fir_accum_mc #(.DWIDTH(16), .ACWIDTH(40), .OWIDTH(16), .SHIFT(2), .ROUND(1), .CHANNELS(5)) u_a (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .valid_i(vld), .first_i(fst), .last_i(lst),
      .chan_i(ch), .data_i(din), .valid_o(va), .chan_o(cha), .data_o(da), .sat_o(sa), .err_o(ea));
   fir_accum_mc #(.DWIDTH(16), .ACWIDTH(40), .OWIDTH(16), .SHIFT(2), .ROUND(0), .CHANNELS(5)) u_b (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .valid_i(vld), .first_i(fst), .last_i(lst),
      .chan_i(ch), .data_i(din), .valid_o(vb), .chan_o(chb), .data_o(db), .sat_o(sb), .err_o(eb));
   fir_accum_mc #(.DWIDTH(16), .ACWIDTH(40), .OWIDTH(16), .SHIFT(0), .ROUND(1), .CHANNELS(5)) u_c (
      .clk_i(clk), .rst_i(rst), .clr_i(clr), .valid_i(vld), .first_i(fst), .last_i(lst),
      .chan_i(ch), .data_i(din), .valid_o(vc), .chan_o(chc), .data_o(dc), .sat_o(sc), .err_o(ec));

   typedef struct {
      int chan;
      int data;
      bit sat;
      int at_edge;
   } exp_t;

   exp_t qa[$], qb[$], qc[$];
   int checks = 0;
   int errors = 0;
   int edges = 0;
   int err_pulses = 0;

   always @(posedge clk) edges <= edges + 1;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic pop_cmp(input int idx, input int c, input int d, input bit s);
      exp_t e;
      bit have;
      have = 1'b0;
      case (idx)
         0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
         1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
         2: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
         default: ;
      endcase
      if (!have) begin
         checks++;
         errors++;
         $display("FAIL unexpected_valid inst=%0d actual chan=%0d data=%0d required no output", idx, c, d);
      end else begin
         check($sformatf("latency_i%0d", idx), edges, e.at_edge);
         check($sformatf("chan_i%0d", idx), c, e.chan);
         check($sformatf("data_i%0d", idx), d, e.data);
         check($sformatf("sat_i%0d", idx), s, e.sat);
      end
   endtask

   // Monitor: compare every presented result against the head of its queue.
   always @(negedge clk) begin
      if (va) pop_cmp(0, int'(cha), int'(da), sa);
      if (vb) pop_cmp(1, int'(chb), int'(db), sb);
      if (vc) pop_cmp(2, int'(chc), int'(dc), sc);
      err_pulses += int'(ea) + int'(eb) + int'(ec);
   end

   task automatic drive(input bit v, input bit f, input bit l, input int c, input int d,
                        input bit cl = 1'b0);
      @(negedge clk);
      vld = v;
      fst = f;
      lst = l;
      ch  = CHW'(c);
      din = 16'(d);
      clr = cl;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   // Called right after driving a last sample: result due two edges later.
   task automatic push(input int c, input int xa, input bit ya, input int xb, input bit yb,
                       input int xc, input bit yc);
      qa.push_back('{c, xa, ya, edges + 2});
      qb.push_back('{c, xb, yb, edges + 2});
      qc.push_back('{c, xc, yc, edges + 2});
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, va, 0);
      check({tag, "_data"}, da, 0);
      check({tag, "_chan"}, cha, 0);
      check({tag, "_sat"}, sa, 0);
      check({tag, "_err"}, ea, 0);
      check({tag, "_valid_c"}, vc, 0);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; vld = 1'b0; fst = 1'b0; lst = 1'b0; ch = '0; din = '0;
      repeat (3) @(negedge clk);
      check_reset_state("por");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("por_after_valid", va, 0);

      // ch1 5,6,7 -> sum 18
      drive(1, 1, 0, 1, 5);
      drive(1, 0, 0, 1, 6);
      drive(1, 0, 1, 1, 7);
      push(1, 5, 0, 4, 0, 18, 0);

      // interleaved ch0 / ch3, back-to-back lasts: sums 60 and -6
      drive(1, 1, 0, 0, 10);
      drive(1, 1, 0, 3, -1);
      drive(1, 0, 0, 0, 20);
      drive(1, 0, 0, 3, -2);
      drive(1, 0, 1, 0, 30);
      push(0, 15, 0, 15, 0, 60, 0);
      drive(1, 0, 1, 3, -3);
      push(3, -1, 0, -2, 0, -6, 0);

      // ch2 4 x 32767 = 131068: exactly max after shift, clamped only at SHIFT=0
      drive(1, 1, 0, 2, 32767);
      drive(1, 0, 0, 2, 32767);
      drive(1, 0, 0, 2, 32767);
      drive(1, 0, 1, 2, 32767);
      push(2, 32767, 0, 32767, 0, 32767, 1);

      // ch2 2 x -32768 = -65536
      drive(1, 1, 0, 2, -32768);
      drive(1, 0, 1, 2, -32768);
      push(2, -16384, 0, -16384, 0, -32768, 1);

      drive(1, 1, 1, 2, 100);
      push(2, 25, 0, 25, 0, 100, 0);

      // ch1 8 x 32767 = 262136: clamps in every build
      drive(1, 1, 0, 1, 32767);
      for (int i = 0; i < 6; i++) drive(1, 0, 0, 1, 32767);
      drive(1, 0, 1, 1, 32767);
      push(1, 32767, 1, 32767, 1, 32767, 1);

      // rounding boundary
      drive(1, 1, 1, 0, -3);
      push(0, -1, 0, -1, 0, -3, 0);
      drive(1, 1, 1, 0, -2);
      push(0, 0, 0, -1, 0, -2, 0);

      // clear: ch3 result in flight survives, dropped ch0 last, ch0 restarts from 0
      drive(1, 1, 0, 0, 100);
      drive(1, 1, 1, 3, 8);
      push(3, 2, 0, 2, 0, 8, 0);
      drive(1, 0, 1, 0, 50, 1'b1);
      drive(1, 0, 1, 0, 4);
      push(0, 1, 0, 1, 0, 4, 0);

      // reset mid-operation: ch2 9 is in flight and lost, ch0 restarts from 0
      drive(1, 1, 0, 0, 100);
      drive(1, 1, 1, 2, 9);
      drive(1, 0, 1, 0, 50);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      check_reset_state("mid_rst");
      idle();
      check("mid_rst_after_valid", va, 0);
      drive(1, 0, 1, 0, 4);
      push(0, 1, 0, 1, 0, 4, 0);

      // invalid channel leaves ch4 intact: 11 + 2 = 13
      drive(1, 1, 0, 4, 11);
      drive(1, 0, 1, 5, 77);
      idle();
      check("err_pulse_a", ea, 1);
      check("err_pulse_c", ec, 1);
      idle();
      check("err_one_cycle", ea, 0);
      drive(1, 0, 1, 4, 2);
      push(4, 3, 0, 3, 0, 13, 0);

      // invalid channel with clear still flags; clear wipes ch4
      drive(1, 1, 0, 4, 20);
      drive(1, 0, 1, 6, 5, 1'b1);
      idle();
      check("err_with_clr", ea, 1);
      drive(1, 0, 1, 4, 8);
      push(4, 2, 0, 2, 0, 8, 0);

      idle();
      for (int i = 0; i < 20 && (qa.size() + qb.size() + qc.size()) > 0; i++) @(negedge clk);
      check("drain_pending", qa.size() + qb.size() + qc.size(), 0);
      repeat (3) @(negedge clk);
      check("err_pulse_total", err_pulses, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_accum_mc.md
Name: fir_accum_mc

Overview:
- Multi-channel, time-interleaved accumulator bank for the FIR family. Gives each channel its own partial-sum register and accepts one product per cycle, with channels in any order.
- Framing flags mark the start and end of each sum. At end of sum the block rounds, shifts and saturates the result to the output width and emits it with the channel tag.
- Sits after the tap multiplier in multi-channel and polyphase FIR datapaths.

Parameters:
- DWIDTH, 16: signed input (product) width.
- ACWIDTH, 40: signed accumulator width; must be at least DWIDTH.
- OWIDTH, 16: signed output width; must not exceed ACWIDTH.
- SHIFT, 15: arithmetic right shift applied at output; 0 to ACWIDTH-1.
- ROUND, 1: 1 = round half-up before the shift; 0 = truncate.
- CHANNELS, 4: number of accumulators; at least 1.
- CHW, $clog2(CHANNELS) with a minimum of 1: channel index width (derived localparam).

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- clr_i  in  1  zeroes all accumulators.
- valid_i  in  1  data_i/chan_i/first_i/last_i qualify this cycle.
- first_i  in  1  sample starts a new sum (load, do not add).
- last_i  in  1  sample ends the sum; emit the result.
- chan_i  in  CHW  channel index.
- data_i  in  DWIDTH  signed sample.
- valid_o  out  1  one-cycle pulse; result valid.
- chan_o  out  CHW  channel of the result.
- data_o  out  OWIDTH  signed result.
- sat_o  out  1  result was clamped; qualified by valid_o.
- err_o  out  1  one-cycle pulse when chan_i >= CHANNELS with valid_i.

Behaviour:
- Reset:
  - All accumulators are 0.
  - valid_o, sat_o and err_o are 0; chan_o and data_o are 0.
  - Pipeline is flushed: no valid_o in the cycle after rst_i deasserts, and any sum in flight at reset is lost.
- Stage 0, sample accept (cycle N):
  - Accepting condition: valid_i, chan_i < CHANNELS and clr_i low.
  - sum = (first_i ? 0 : acc[chan_i]) + sign-extended data_i, computed in ACWIDTH bits with two's-complement wrap and no overflow detection.
  - acc[chan_i] <= sum. Accumulators of other channels are untouched.
- Stage 1 (registered at N+1): when an accepted sample had last_i set, capture sum and chan_i.
- Stage 2, output (valid_o at N+2):
  - r = sum + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0), evaluated in ACWIDTH+1 bits so rounding cannot wrap.
  - q = r >>> SHIFT.
  - If q > 2^(OWIDTH-1)-1, data_o = max and sat_o = 1. If q < -2^(OWIDTH-1), data_o = min and sat_o = 1. Otherwise data_o = q and sat_o = 0.
  - Outputs are registered. data_o, chan_o and sat_o hold until the next valid_o.
- Latency and throughput:
  - Fixed 2 cycles from the last_i sample to valid_o.
  - Full throughput: one sample per cycle, with back-to-back last_i on any channels.
  - No backpressure; the consumer must accept every valid_o.
- first_i and last_i together: a single-sample sum, so the result is data_i rounded and shifted.
- first_i without a previous last_i on that channel: the old partial sum is discarded silently.
- Non-first sample on a channel after clr_i or reset: adds to 0.
- clr_i:
  - Zeroes all accumulators at the next edge.
  - A valid_i in the same cycle is dropped, including its last_i, so no output is produced for it.
  - Results already in stages 1 and 2 still emerge.
- Invalid channel: chan_i >= CHANNELS with valid_i gives no state change, err_o = 1 for one cycle, and no output even if last_i is set. Whether the channel is invalid is checked before clr_i priority.
- rst_i takes precedence over clr_i, which takes precedence over valid_i.

Test Plan:
- Single channel (SHIFT=2, ROUND=1, OWIDTH=16). Feed ch1 samples 5(first), 6, 7(last) on consecutive cycles -> valid_o two cycles after the 7, chan_o=1, data_o=5 (18+2=20, >>2), sat_o=0.
- Interleaving (SHIFT=2). Alternate ch0 10(first), 20, 30(last) with ch3 -1(first), -2, -3(last) -> ch0 result data_o=15, then ch3 result data_o=-1 on the next cycle; accumulators must not cross-contaminate.
- Saturation (SHIFT=0).
  - ch2 32767 four times, first/last framed -> data_o=32767, sat_o=1.
  - ch2 -32768 twice -> data_o=-32768, sat_o=1.
  - ch2 100 once (first+last) -> data_o=100, sat_o=0.
- Rounding boundary (SHIFT=2).
  - first+last -3 -> data_o=-1.
  - first+last -2 -> data_o=0.
  - ROUND=0 with -3 -> data_o=-1 (floor).
- Clear and reset mid-operation.
  - ch0 100(first), then clr_i together with ch0 50(last) -> no valid_o; a following non-first ch0 4(last) -> data_o=4>>SHIFT, accumulated from 0.
  - Repeat with rst_i in place of clr_i -> same result, and valid_o=0 in the cycle after reset.
- Invalid channel (CHANNELS=4). valid_i with chan_i=5 (CHW=2 build: use CHANNELS=5 bound test with chan_i=5 on CHW=3) and last_i set -> err_o pulses one cycle, no valid_o, and all accumulators unchanged.
